branch_predictor: RTL

Dynamic branch predictor for the RV32I core: a direct-mapped table of 2-bit saturating counters indexed by PC. Fetch looks it up with a one-cycle registered result; execute trains it with the resolved outcome from the branch comparator and receives a registered mispredict flag. The predictor also keeps saturating statistics counters for branches and mispredicts, readable by the UART debug path.

---
 rtl/bp_pkg.sv | 15 +
 rtl/bp_sat_ctr.sv | 23 ++
 rtl/branch_predictor.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor.
// Counter encoding, counter type and statistics saturation value.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;
    localparam ctr_t CTR_RST = CTR_WNT;

    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating counter next-state logic.
// Taken counts up to strong-T, not-taken counts down to strong-NT.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] nxt
);

    // saturating step in the direction of the outcome
    always_comb begin
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST)
                nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT)
                nxt = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter branch predictor with statistics.
// Optional target buffer enabled by defining BP_BTB_EN.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_valid,
    input  logic [31:0] f_pc,
    output logic        p_valid,
    output logic        p_taken,
    output logic        p_hit,
    output logic [31:0] p_target,
    input  logic        u_valid,
    input  logic [31:0] u_pc,
    input  logic        u_taken,
    input  logic [31:0] u_target,
    input  logic        u_pred_taken,
    input  logic [31:0] u_pred_target,
    output logic        u_mispredict,
    output logic [31:0] cnt_branch,
    output logic [31:0] cnt_mispredict
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = 32 - IDX - 2;

    logic [IDX-1:0] fidx;
    logic [IDX-1:0] uidx;
    ctr_t           ctr_q [ENTRIES];
    logic [1:0]     ctr_nxt;
    logic           l_taken;
    logic           l_hit;
    logic [31:0]    l_tgt;
    logic           tgt_mp;
    logic           mp;
    logic [31:0]    stat_br_q;
    logic [31:0]    stat_mp_q;

    assign fidx = f_pc[IDX+1:2];
    assign uidx = u_pc[IDX+1:2];

    bp_sat_ctr u_sat (
        .ctr   (ctr_q[uidx]),
        .taken (u_taken),
        .nxt   (ctr_nxt)
    );

`ifdef BP_BTB_EN
    logic          btb_v   [ENTRIES];
    logic [TW-1:0] btb_tag [ENTRIES];
    logic [31:0]   btb_tgt [ENTRIES];
    logic [3:0]    unused_ok;

    assign l_hit   = btb_v[fidx] && (btb_tag[fidx] == f_pc[31:IDX+2]);
    assign l_tgt   = l_hit ? btb_tgt[fidx] : 32'd0;
    assign l_taken = ctr_q[fidx][1] & l_hit;
    assign tgt_mp  = u_taken & u_pred_taken
                   & (u_target != u_pred_target);
    assign unused_ok = {f_pc[1:0], u_pc[1:0]};

    // valid bits need reset; set on taken resolution
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                btb_v[i] <= 1'b0;
        end else if (u_valid && u_taken) begin
            btb_v[uidx] <= 1'b1;
        end
    end

    // tag and target are qualified by the valid bit
    always_ff @(posedge clk) begin
        if (u_valid && u_taken) begin
            btb_tag[uidx] <= u_pc[31:IDX+2];
            btb_tgt[uidx] <= u_target;
        end
    end
`else
    logic unused_ok;

    assign l_hit   = 1'b0;
    assign l_tgt   = 32'd0;
    assign l_taken = ctr_q[fidx][1];
    assign tgt_mp  = 1'b0;
    assign unused_ok = ^{u_target, u_pred_target,
                         f_pc[31:IDX+2], f_pc[1:0],
                         u_pc[31:IDX+2], u_pc[1:0]};
`endif

    assign mp = u_valid & ((u_taken != u_pred_taken) | tgt_mp);

    // counter table: train on resolved branches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr_q[i] <= CTR_RST;
        end else if (u_valid) begin
            ctr_q[uidx] <= ctr_nxt;
        end
    end

    // lookup result reads pre-update table state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid  <= 1'b0;
            p_taken  <= 1'b0;
            p_hit    <= 1'b0;
            p_target <= 32'd0;
        end else begin
            p_valid <= f_valid;
            if (f_valid) begin
                p_taken  <= l_taken;
                p_hit    <= l_hit;
                p_target <= l_tgt;
            end
        end
    end

    // registered mispredict pulse and saturating statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_mispredict <= 1'b0;
            stat_br_q    <= 32'd0;
            stat_mp_q    <= 32'd0;
        end else begin
            u_mispredict <= mp;
            if (u_valid && stat_br_q != STAT_MAX)
                stat_br_q <= stat_br_q + 32'd1;
            if (mp && stat_mp_q != STAT_MAX)
                stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign cnt_branch     = stat_br_q;
    assign cnt_mispredict = stat_mp_q;

endmodule
